johnson_phase_monitor: RTL and testbench
========================================

// Module: johnson_phase_monitor
// PURPOSE
//  Consumer stage that sits directly downstream of the Johnson counter.
//  - Samples the counter's WIDTH-bit code and decodes it to a one-hot phase and a binary index.
//  - Checks that each code is legal and that successive codes follow the Johnson sequence.
//  - Counts full revolutions (index 2*WIDTH-1 -> 0).
//  Feeds phase-driven logic (strobes, stepper drive) and exposes sticky error status.
// PARAMETERS
//  WIDTH   4  Johnson register width; sequence length N = 2*WIDTH.
//  REV_W   8  Revolution counter width.
//  IDX_W   $clog2(2*WIDTH)  Index width; localparam, derived.
// PORTS
//  Clock         in   1        Single clock; all logic on rising edge.
//  Reset         in   1        Synchronous, active-high; clears all state.
//  Count_in      in   WIDTH    Johnson code from the upstream counter.
//  Enable        in   1        Sample strobe; when 0, all state and outputs hold.
//  Err_clear     in   1        Clears Illegal_code and Seq_error (one-cycle pulse).
//  Phase_out     out  2*WIDTH  One-hot decoded phase; all-zero when not locked.
//  Phase_idx     out  IDX_W    Binary phase index; 0 when not locked.
//  Locked        out  1        1 once a legal code is tracked.
//  Rev_count     out  REV_W    Completed revolutions, wraps modulo 2^REV_W.
//  Illegal_code  out  1        Sticky: a non-Johnson code was sampled.
//  Seq_error     out  1        Sticky: a legal code arrived out of sequence.
// BEHAVIOUR
//  - Reset: state=UNLOCKED; Phase_out=0, Phase_idx=0, Locked=0, Rev_count=0,
//    Illegal_code=0, Seq_error=0. Reset overrides Enable and Err_clear.
//  - Legal code table, k in 0..N-1:
//    - k<WIDTH: low k bits set, all others 0.
//    - k>=WIDTH: high (N-k) bits set, all others 0.
//    - WIDTH=4 sequence: 0000,0001,0011,0111,1111,1110,1100,1000 -> k=0..7.
//    - All other codes are illegal; exactly 2^WIDTH-N of them.
//  - Latency: outputs reflect the Count_in sampled with Enable=1 on the previous edge (1 cycle).
//  - FSM, evaluated only when Enable=1:
//    - UNLOCKED:
//      - legal k -> LOCKED; Phase_idx=k; Phase_out=1<<k; Locked=1.
//      - illegal -> stay UNLOCKED; set Illegal_code.
//    - LOCKED, previous index p:
//      - k==p: hold (stalled upstream is legal); no flag.
//      - k==(p+1) mod N: advance. If p==N-1 and k==0, Rev_count+=1 (wraps to 0 after 2^REV_W-1).
//      - other legal k: resync to k; set Seq_error; Rev_count unchanged.
//      - illegal -> UNLOCKED; Phase_out=0, Phase_idx=0, Locked=0; set Illegal_code.
//  - Upstream reset mid-run (code jumps to 0000 from p not in {0,N-1}) is a resync and sets
//    Seq_error by design. The p==N-1 case is a normal advance and counts a revolution.
//  - Err_clear clears both sticky flags at the edge. If a new error is detected on the same
//    edge, that flag ends set (set wins). Err_clear acts regardless of Enable.
//  - Phase_out is always one-hot or all-zero; never multi-hot.
// TESTING
//  1. Reset, then Enable=1, feed 0000..1000 x3 then 0000 (WIDTH=4):
//     Locked=1 from cycle 2; Phase_out walks 0x01..0x80; Rev_count=3; no flags.
//  2. Locked at k=2 (0011), feed 0011 for 5 cycles with Enable=1:
//     Phase_idx stays 2; no flags; Rev_count unchanged.
//  3. Locked at k=5 (1110), feed 0101 (illegal):
//     next cycle Locked=0, Phase_out=0, Illegal_code=1; then 0111 relocks at k=3, flag stays 1.
//  4. Locked at k=1, feed 1100 (k=6):
//     Seq_error=1, Phase_idx=6, Locked=1. Err_clear pulse -> Seq_error=0.
//     Err_clear coincident with a new skip -> Seq_error=1.
//  5. REV_W=2, run 4 full revolutions: Rev_count 1,2,3,0. Enable=0 mid-run: all outputs frozen.
//  6. Assert Reset while locked at k=4 with Enable=1 and an illegal code present:
//     all outputs 0 next cycle, no flags.

Source files
------------

// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor
//
// Consumer stage that sits directly downstream of a Johnson counter. Each
// enabled clock it samples the counter's WIDTH-bit code, decodes it to a
// one-hot phase and a binary index, checks that the code is legal and that
// it follows the Johnson sequence, and counts completed revolutions.
//
// Parameters
//   WIDTH  Johnson register width; sequence length N = 2*WIDTH
//   REV_W  revolution counter width
//
// Ports
//   Clock         in   rising-edge clock
//   Reset         in   synchronous, active-high; clears all state
//   Count_in      in   [WIDTH-1:0] Johnson code from upstream
//   Enable        in   sample strobe; when low all state and outputs hold
//   Err_clear     in   clears both sticky flags (acts regardless of Enable)
//   Phase_out     out  [2*WIDTH-1:0] one-hot phase, all-zero when unlocked
//   Phase_idx     out  [IDX_W-1:0] binary phase index, 0 when unlocked
//   Locked        out  a legal code is being tracked
//   Rev_count     out  [REV_W-1:0] completed revolutions, wraps
//   Illegal_code  out  sticky: a non-Johnson code was sampled
//   Seq_error     out  sticky: a legal code arrived out of sequence

module johnson_phase_monitor #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [WIDTH-1:0]              Count_in,
    input  logic                          Enable,
    input  logic                          Err_clear,
    output logic [2*WIDTH-1:0]            Phase_out,
    output logic [$clog2(2*WIDTH)-1:0]    Phase_idx,
    output logic                          Locked,
    output logic [REV_W-1:0]              Rev_count,
    output logic                          Illegal_code,
    output logic                          Seq_error
);

    localparam int N     = 2 * WIDTH;
    localparam int IDX_W = $clog2(N);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [REV_W-1:0]  rev, rev_next;
    logic              illegal, illegal_next;
    logic              seq_err, seq_err_next;

    logic              code_legal;
    logic [IDX_W-1:0]  code_idx;
    logic [IDX_W-1:0]  succ_idx;

    // Johnson code for position k: the low k bits set during the fill half,
    // then the high N-k bits set during the drain half.
    function automatic logic [WIDTH-1:0] johnson_code(input int k);
        logic [WIDTH-1:0] ones;
        ones = '1;
        if (k < WIDTH) begin
            return ~(ones << k);
        end
        return ones << (k - WIDTH);
    endfunction

    // Match the sampled code against every legal Johnson code. At most one
    // entry can match since the N codes are distinct.
    always_comb begin
        code_legal = 1'b0;
        code_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (Count_in == johnson_code(k)) begin
                code_legal = 1'b1;
                code_idx   = IDX_W'(k);
            end
        end
    end

    assign succ_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;

    // Next-state logic. Sticky flags are cleared first by Err_clear and then
    // re-set by any error detected on the same edge, so a new error wins.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        rev_next     = rev;
        illegal_next = illegal & ~Err_clear;
        seq_err_next = seq_err & ~Err_clear;

        if (Enable) begin
            case (state)
                UNLOCKED: begin
                    if (code_legal) begin
                        state_next = LOCKED;
                        idx_next   = code_idx;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!code_legal) begin
                        state_next   = UNLOCKED;
                        idx_next     = '0;
                        illegal_next = 1'b1;
                    end else if (code_idx == idx) begin
                        // A stalled upstream counter repeats its code; not an error.
                        idx_next = idx;
                    end else if (code_idx == succ_idx) begin
                        idx_next = code_idx;
                        if (idx == LAST_IDX) begin
                            rev_next = rev + 1'b1;
                        end
                    end else begin
                        // Legal but out of order, including an upstream reset
                        // to code 0 from mid-sequence: follow the new position.
                        idx_next     = code_idx;
                        seq_err_next = 1'b1;
                    end
                end
                default: begin
                    state_next = UNLOCKED;
                    idx_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= UNLOCKED;
            idx     <= '0;
            rev     <= '0;
            illegal <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            rev     <= rev_next;
            illegal <= illegal_next;
            seq_err <= seq_err_next;
        end
    end

    // The index register is forced to 0 whenever tracking is lost, so the
    // one-hot decode only needs gating by the lock state.
    assign Locked       = (state == LOCKED);
    assign Phase_idx    = idx;
    assign Phase_out    = Locked ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
    assign Rev_count    = rev;
    assign Illegal_code = illegal;
    assign Seq_error    = seq_err;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// tb_johnson_phase_monitor
//
// Directed bench for johnson_phase_monitor with WIDTH=4 and REV_W=2. The
// driver applies one input vector per cycle and queues the hand-computed
// outputs expected after the following rising edge; an independent monitor
// pops that queue after every rising edge and compares each output field.

module tb_johnson_phase_monitor;

    logic       Clock;
    logic       Reset;
    logic [3:0] Count_in;
    logic       Enable;
    logic       Err_clear;
    logic [7:0] Phase_out;
    logic [2:0] Phase_idx;
    logic       Locked;
    logic [1:0] Rev_count;
    logic       Illegal_code;
    logic       Seq_error;

    int tests;
    int failures;
    int stepNum;

    typedef struct {
        int         step;
        logic       locked;
        logic [2:0] idx;
        logic [1:0] rev;
        logic       ill;
        logic       seq;
    } exp_t;

    exp_t scoreboard[$];

    // Hand-listed Johnson sequence for WIDTH=4, position k = 0..7.
    localparam logic [3:0] J [0:7] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111,
        4'b1111, 4'b1110, 4'b1100, 4'b1000
    };

    johnson_phase_monitor #(
        .WIDTH(4),
        .REV_W(2)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Count_in     (Count_in),
        .Enable       (Enable),
        .Err_clear    (Err_clear),
        .Phase_out    (Phase_out),
        .Phase_idx    (Phase_idx),
        .Locked       (Locked),
        .Rev_count    (Rev_count),
        .Illegal_code (Illegal_code),
        .Seq_error    (Seq_error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input int step, input string field,
                               input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL step%0d %s: got %0h want %0h", step, field, got, want);
        end
    endtask

    // Drive one vector between edges and queue what the outputs must be once
    // the next rising edge has taken it.
    task automatic applyStimulus(input logic rst, input logic en, input logic clr,
                                 input logic [3:0] code,
                                 input logic el, input logic [2:0] ei,
                                 input logic [1:0] er, input logic eil,
                                 input logic es);
        exp_t e;
        @(negedge Clock);
        Reset     = rst;
        Enable    = en;
        Err_clear = clr;
        Count_in  = code;
        stepNum++;
        e.step   = stepNum;
        e.locked = el;
        e.idx    = ei;
        e.rev    = er;
        e.ill    = eil;
        e.seq    = es;
        scoreboard.push_back(e);
    endtask

    // Monitor: the DUT presents a fresh result after every rising edge.
    initial begin
        exp_t e;
        logic [7:0] wantPhase;
        forever begin
            @(posedge Clock);
            #1;
            if (scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                wantPhase = e.locked ? (8'h01 << e.idx) : 8'h00;
                checkOutput(e.step, "Locked",       32'(Locked),       32'(e.locked));
                checkOutput(e.step, "Phase_idx",    32'(Phase_idx),    32'(e.idx));
                checkOutput(e.step, "Phase_out",    32'(Phase_out),    32'(wantPhase));
                checkOutput(e.step, "Rev_count",    32'(Rev_count),    32'(e.rev));
                checkOutput(e.step, "Illegal_code", 32'(Illegal_code), 32'(e.ill));
                checkOutput(e.step, "Seq_error",    32'(Seq_error),    32'(e.seq));
            end
        end
    end

    initial begin
        tests     = 0;
        failures  = 0;
        stepNum   = 0;
        Reset     = 1'b1;
        Enable    = 1'b0;
        Err_clear = 1'b0;
        Count_in  = 4'b0000;

        // Reset state
        applyStimulus(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0);

        // Three clean revolutions then the closing 0000
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) begin
                applyStimulus(0, 1, 0, J[k], 1, 3'(k), 2'(r), 0, 0);
            end
        end
        applyStimulus(0, 1, 0, J[0], 1, 0, 3, 0, 0);

        // Fourth revolution wraps the 2-bit counter to 0
        for (int k = 1; k < 8; k++) begin
            applyStimulus(0, 1, 0, J[k], 1, 3'(k), 3, 0, 0);
        end
        applyStimulus(0, 1, 0, J[0], 1, 0, 0, 0, 0);
        for (int k = 1; k < 4; k++) begin
            applyStimulus(0, 1, 0, J[k], 1, 3'(k), 0, 0, 0);
        end

        // Enable low: illegal, skipping and reset-like codes are all ignored
        applyStimulus(0, 0, 0, 4'b0101, 1, 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 4'b1100, 1, 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 4'b0000, 1, 3, 0, 0, 0);
        for (int k = 4; k < 8; k++) begin
            applyStimulus(0, 1, 0, J[k], 1, 3'(k), 0, 0, 0);
        end
        applyStimulus(0, 1, 0, J[0], 1, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, J[1], 1, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, J[2], 1, 2, 1, 0, 0);

        // Stalled upstream at k=2
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, J[2], 1, 2, 1, 0, 0);
        end

        // Advance to k=1
        for (int k = 3; k < 8; k++) begin
            applyStimulus(0, 1, 0, J[k], 1, 3'(k), 1, 0, 0);
        end
        applyStimulus(0, 1, 0, J[0], 1, 0, 2, 0, 0);
        applyStimulus(0, 1, 0, J[1], 1, 1, 2, 0, 0);

        // Skip 1 -> 6, clear, then clear coincident with a new skip
        applyStimulus(0, 1, 0, J[6], 1, 6, 2, 0, 1);
        applyStimulus(0, 1, 1, J[6], 1, 6, 2, 0, 0);
        applyStimulus(0, 1, 0, J[7], 1, 7, 2, 0, 0);
        applyStimulus(0, 1, 1, J[2], 1, 2, 2, 0, 1);
        applyStimulus(0, 1, 1, J[2], 1, 2, 2, 0, 0);

        // Illegal code from k=5, relock at k=3, illegal while unlocked
        for (int k = 3; k < 6; k++) begin
            applyStimulus(0, 1, 0, J[k], 1, 3'(k), 2, 0, 0);
        end
        applyStimulus(0, 1, 0, 4'b0101, 0, 0, 2, 1, 0);
        applyStimulus(0, 1, 0, J[3],    1, 3, 2, 1, 0);
        applyStimulus(0, 1, 0, 4'b0101, 0, 0, 2, 1, 0);
        applyStimulus(0, 1, 0, J[4],    1, 4, 2, 1, 0);

        // Err_clear acts with Enable low
        applyStimulus(0, 0, 1, 4'b0101, 1, 4, 2, 0, 0);

        // Upstream reset from k=4 is a resync, no revolution counted
        applyStimulus(0, 1, 0, J[0], 1, 0, 2, 0, 1);
        for (int k = 1; k < 8; k++) begin
            applyStimulus(0, 1, 0, J[k], 1, 3'(k), 2, 0, 1);
        end
        applyStimulus(0, 1, 0, J[0], 1, 0, 3, 0, 1);
        for (int k = 1; k < 5; k++) begin
            applyStimulus(0, 1, 0, J[k], 1, 3'(k), 3, 0, 1);
        end

        // Reset overrides Enable with an illegal code present
        applyStimulus(1, 1, 0, 4'b0101, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 4'b0101, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 1, 4'b0101, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 1, J[0],    1, 0, 0, 0, 0);

        // Let the monitor drain the scoreboard, with a bounded wait
        for (int i = 0; i < 10 && scoreboard.size() > 0; i++) begin
            @(posedge Clock);
        end
        #2;
        if (scoreboard.size() > 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending want 0", scoreboard.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
